// File: rtl/uart_frame_decoder_pkg.sv
// Shared constants and types for the UART frame decoder.
package uart_frame_pkg;

    localparam logic [7:0] SOF_BYTE = 8'hA5;
    localparam logic [7:0] CMD_LED  = 8'h01;

    typedef enum logic [1:0] {
        ERR_NONE = 2'd0,
        ERR_LEN  = 2'd1,
        ERR_CHK  = 2'd2,
        ERR_TMO  = 2'd3
    } err_code_t;

    typedef enum logic [2:0] {
        S_HUNT = 3'd0,
        S_CMD  = 3'd1,
        S_LEN  = 3'd2,
        S_PAY  = 3'd3,
        S_CHK  = 3'd4
    } state_t;

endpackage

// File: rtl/uart_frame_decoder_if.sv
// Byte-stream input from uart_rx and decoded frame outputs.
interface uart_frame_decoder_if;
    logic       data_vld_i;
    logic [7:0] data_i;
    logic       pl_vld_o;
    logic [7:0] pl_data_o;
    logic [7:0] pl_idx_o;
    logic       frame_ok_o;
    logic       frame_err_o;
    logic [1:0] err_code_o;
    logic [7:0] cmd_o;
    logic [7:0] len_o;
    logic [3:0] led_o;

    modport master (
        output data_vld_i, data_i,
        input  pl_vld_o, pl_data_o, pl_idx_o, frame_ok_o, frame_err_o,
               err_code_o, cmd_o, len_o, led_o
    );

    modport slave (
        input  data_vld_i, data_i,
        output pl_vld_o, pl_data_o, pl_idx_o, frame_ok_o, frame_err_o,
               err_code_o, cmd_o, len_o, led_o
    );
endinterface

// File: rtl/uart_frame_decoder_gap_timer.sv
// Inter-byte gap timer. Counts down from TIMEOUT_CYC after each clear and
// holds at zero; expired is high while the remaining count is zero, which is
// the same cycle an elapsed-cycles counter would reach TIMEOUT_CYC.
module uart_gap_timer #(
    parameter int TIMEOUT_CYC = 112500
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int              CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0]   TC = CW'(TIMEOUT_CYC);

    logic [CW-1:0] remain;

    // Reload on clear, otherwise count down and saturate at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remain <= TC;
        end else if (clear) begin
            remain <= TC;
        end else if (enable && (remain != '0)) begin
            remain <= remain - CW'(1);
        end
    end

    assign expired = (remain == '0);

endmodule

// File: rtl/uart_frame_decoder.sv
// Frame parser downstream of uart_rx: SOF, CMD, LEN, payload, CHK.
// Streams payload bytes, flags good/bad frames and owns the LED register.
//
//  state  | meaning
//  -------+-----------------------------------------------
//  S_HUNT | idle, waiting for SOF; other bytes dropped
//  S_CMD  | next byte is CMD, seeds the checksum
//  S_LEN  | next byte is LEN, range-checked against MAX_LEN
//  S_PAY  | payload bytes streamed out with their index
//  S_CHK  | next byte is compared with the running checksum
module uart_frame_decoder
    import uart_frame_pkg::*;
#(
    parameter int CLK_FREQ_Hz   = 27000000,
    parameter int BAUD_RATE     = 9600,
    parameter int MAX_LEN       = 16,
    parameter int TIMEOUT_BYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    uart_frame_decoder_if.slave   bus
);
    // 64-bit so the product cannot overflow before the divide.
    localparam longint unsigned TIMEOUT_CYC_W =
        (longint'(TIMEOUT_BYTES) * 64'd10 * longint'(CLK_FREQ_Hz)) / longint'(BAUD_RATE);
    localparam int TIMEOUT_CYC = int'(TIMEOUT_CYC_W);
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    state_t    state;
    err_code_t err_code_q;
    logic [7:0] chk;
    logic [7:0] idx;
    logic [3:0] pl0_nib;
    logic       pl_vld_q;
    logic [7:0] pl_data_q;
    logic [7:0] pl_idx_q;
    logic       frame_ok_q;
    logic       frame_err_q;
    logic [7:0] cmd_q;
    logic [7:0] len_q;
    logic [3:0] led_q;
    logic       gap_clr;
    logic       gap_expired;

    assign gap_clr = bus.data_vld_i || (state == S_HUNT);

    uart_gap_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_gap_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (gap_clr),
        .enable  (1'b1),
        .expired (gap_expired)
    );

    // Frame FSM with registered strobes, checksum and held outputs.
    // Only the low nibble of payload byte 0 is kept: it is all the LED needs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_HUNT;
            err_code_q  <= ERR_NONE;
            chk         <= '0;
            idx         <= '0;
            pl0_nib     <= '0;
            pl_vld_q    <= 1'b0;
            pl_data_q   <= '0;
            pl_idx_q    <= '0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            cmd_q       <= '0;
            len_q       <= '0;
            led_q       <= '0;
        end else begin
            pl_vld_q    <= 1'b0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            if (bus.data_vld_i) begin
                case (state)
                    S_HUNT: begin
                        if (bus.data_i == SOF_BYTE) state <= S_CMD;
                    end
                    S_CMD: begin
                        cmd_q <= bus.data_i;
                        chk   <= bus.data_i;
                        state <= S_LEN;
                    end
                    S_LEN: begin
                        if ((bus.data_i == 8'd0) || (bus.data_i > MAX_LEN_B)) begin
                            frame_err_q <= 1'b1;
                            err_code_q  <= ERR_LEN;
                            state       <= S_HUNT;
                        end else begin
                            len_q <= bus.data_i;
                            chk   <= chk ^ bus.data_i;
                            idx   <= '0;
                            state <= S_PAY;
                        end
                    end
                    S_PAY: begin
                        pl_vld_q  <= 1'b1;
                        pl_data_q <= bus.data_i;
                        pl_idx_q  <= idx;
                        chk       <= chk ^ bus.data_i;
                        if (idx == 8'd0) pl0_nib <= bus.data_i[3:0];
                        if (idx == (len_q - 8'd1)) begin
                            state <= S_CHK;
                        end else begin
                            idx <= idx + 8'd1;
                        end
                    end
                    S_CHK: begin
                        if (bus.data_i == chk) begin
                            frame_ok_q <= 1'b1;
                            if (cmd_q == CMD_LED) led_q <= pl0_nib;
                        end else begin
                            frame_err_q <= 1'b1;
                            err_code_q  <= ERR_CHK;
                        end
                        state <= S_HUNT;
                    end
                    default: state <= S_HUNT;
                endcase
            end else if (gap_expired && (state != S_HUNT)) begin
                frame_err_q <= 1'b1;
                err_code_q  <= ERR_TMO;
                state       <= S_HUNT;
            end
        end
    end

    assign bus.pl_vld_o    = pl_vld_q;
    assign bus.pl_data_o   = pl_data_q;
    assign bus.pl_idx_o    = pl_idx_q;
    assign bus.frame_ok_o  = frame_ok_q;
    assign bus.frame_err_o = frame_err_q;
    assign bus.err_code_o  = err_code_q;
    assign bus.cmd_o       = cmd_q;
    assign bus.len_o       = len_q;
    assign bus.led_o       = led_q;

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Scoreboard bench for uart_frame_decoder: a frame-buffer reference model
// queues expected strobes as bytes are issued; a monitor pops and compares.
module tb_uart_frame_decoder;
    import uart_frame_pkg::*;

    localparam int CLK_F = 96000;
    localparam int BAUD  = 9600;
    localparam int TMO_B = 4;
    localparam int MAXL  = 16;
    localparam int T     = TMO_B * 10 * CLK_F / BAUD;   // 400 cycles
    localparam int K_PL  = 0;
    localparam int K_OK  = 1;
    localparam int K_ERR = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    uart_frame_decoder_if bus();

    uart_frame_decoder #(
        .CLK_FREQ_Hz   (CLK_F),
        .BAUD_RATE     (BAUD),
        .MAX_LEN       (MAXL),
        .TIMEOUT_BYTES (TMO_B)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        int         kind;
        logic [7:0] data;
        logic [7:0] idx;
        logic [1:0] code;
        logic [7:0] cmd;
        logic [7:0] len;
        logic [3:0] led;
    } exp_t;

    exp_t       sbq[$];
    logic [7:0] fq[$];
    logic [7:0] fr[$];
    logic [7:0] m_cmd, m_len;
    logic [3:0] m_led;
    logic [1:0] m_code;
    int         carry;
    int         tests = 0;
    int         fails = 0;

    function void push_exp(int kind, logic [7:0] d, logic [7:0] i);
        exp_t e;
        e.kind = kind; e.data = d; e.idx = i; e.code = m_code;
        e.cmd = m_cmd; e.len = m_len; e.led = m_led;
        sbq.push_back(e);
    endfunction

    function void model_reset();
        fq.delete(); sbq.delete();
        m_cmd = '0; m_len = '0; m_led = '0; m_code = '0; carry = 0;
    endfunction

    // fq holds the bytes of the open frame (SOF first); gap = idle cycles before b.
    function void model_byte(logic [7:0] b, int gap);
        int n;
        logic [7:0] x;
        if (fq.size() != 0 && gap > T) begin
            m_code = 2'd3; push_exp(K_ERR, 8'h00, 8'h00); fq.delete();
        end
        if (fq.size() == 0) begin
            if (b == 8'hA5) fq.push_back(b);
            return;
        end
        fq.push_back(b);
        n = fq.size();
        if (n == 2) begin
            m_cmd = b;
        end else if (n == 3) begin
            if (b == 8'h00 || int'(b) > MAXL) begin
                m_code = 2'd1; push_exp(K_ERR, 8'h00, 8'h00); fq.delete();
            end else begin
                m_len = b;
            end
        end else if (n <= 3 + int'(fq[2])) begin
            push_exp(K_PL, b, 8'(n - 4));
        end else begin
            x = 8'h00;
            for (int k = 1; k < n - 1; k++) x = x ^ fq[k];
            if (x == b) begin
                if (fq[1] == 8'h01) m_led = fq[3][3:0];
                push_exp(K_OK, 8'h00, 8'h00);
            end else begin
                m_code = 2'd2; push_exp(K_ERR, 8'h00, 8'h00);
            end
            fq.delete();
        end
    endfunction

    task automatic chk(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_evt(int kind);
        exp_t e;
        tests++;
        if (sbq.size() == 0) begin
            fails++;
            $display("FAIL unexpected_strobe: got kind %0d expected none", kind);
            return;
        end
        e = sbq.pop_front();
        if (e.kind != kind ||
            (kind == K_PL && (bus.pl_data_o != e.data || bus.pl_idx_o != e.idx)) ||
            bus.err_code_o != e.code || bus.cmd_o != e.cmd ||
            bus.len_o != e.len || bus.led_o != e.led) begin
            fails++;
            $display("FAIL strobe_event: got kind=%0d data=%h idx=%0d code=%0d cmd=%h len=%h led=%h expected kind=%0d data=%h idx=%0d code=%0d cmd=%h len=%h led=%h",
                     kind, bus.pl_data_o, bus.pl_idx_o, bus.err_code_o, bus.cmd_o, bus.len_o, bus.led_o,
                     e.kind, e.data, e.idx, e.code, e.cmd, e.len, e.led);
        end
    endtask

    // Monitor: every strobe the DUT presents is matched against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.pl_vld_o)    check_evt(K_PL);
            if (bus.frame_ok_o)  check_evt(K_OK);
            if (bus.frame_err_o) check_evt(K_ERR);
            if (bus.frame_ok_o && bus.frame_err_o) begin
                tests++; fails++;
                $display("FAIL ok_err_overlap: got both strobes expected at most one");
            end
        end
    end

    task automatic send(logic [7:0] b, int gap);
        model_byte(b, gap + carry);
        carry = 0;
        repeat (gap) @(negedge clk);
        bus.data_vld_i = 1'b1;
        bus.data_i     = b;
        @(negedge clk);
        bus.data_vld_i = 1'b0;
    endtask

    task automatic idle(int g);
        carry += g;
        if (fq.size() != 0 && carry > T) begin
            m_code = 2'd3; push_exp(K_ERR, 8'h00, 8'h00); fq.delete();
        end
        repeat (g) @(negedge clk);
    endtask

    task automatic build_frame(logic [7:0] cmd, int len, logic [7:0] p0, bit corrupt);
        logic [7:0] x, p;
        fr.delete();
        fr.push_back(8'hA5); fr.push_back(cmd); fr.push_back(8'(len));
        x = cmd ^ 8'(len);
        for (int i = 0; i < len; i++) begin
            p = (i == 0) ? p0 : 8'($urandom_range(0, 255));
            fr.push_back(p);
            x = x ^ p;
        end
        if (corrupt) x = x ^ 8'(1 << $urandom_range(0, 7));
        fr.push_back(x);
    endtask

    task automatic send_fr(int gmax);
        foreach (fr[i]) send(fr[i], (gmax == 0) ? 0 : int'($urandom_range(0, gmax)));
    endtask

    task automatic check_zero(string tag);
        chk({tag, "_pl_vld"},   int'(bus.pl_vld_o), 0);
        chk({tag, "_pl_data"},  int'(bus.pl_data_o), 0);
        chk({tag, "_pl_idx"},   int'(bus.pl_idx_o), 0);
        chk({tag, "_ok"},       int'(bus.frame_ok_o), 0);
        chk({tag, "_err"},      int'(bus.frame_err_o), 0);
        chk({tag, "_err_code"}, int'(bus.err_code_o), 0);
        chk({tag, "_cmd"},      int'(bus.cmd_o), 0);
        chk({tag, "_len"},      int'(bus.len_o), 0);
        chk({tag, "_led"},      int'(bus.led_o), 0);
        chk({tag, "_state"},    int'(dut.state), int'(S_HUNT));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish within 100000 cycles");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        logic [7:0] c;
        bus.data_vld_i = 1'b0;
        bus.data_i     = 8'h00;
        model_reset();
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // LED command frame, single payload byte
        build_frame(8'h01, 1, 8'h07, 1'b0); send_fr(0); idle(2);
        chk("t1_led", int'(bus.led_o), 'h7);
        chk("t1_cmd", int'(bus.cmd_o), 'h01);
        chk("t1_len", int'(bus.len_o), 'h01);

        // non-LED command, three payload bytes
        build_frame(8'h02, 3, 8'h11, 1'b0); send_fr(0); idle(2);
        chk("t2_led_kept", int'(bus.led_o), 'h7);

        // checksum error leaves LED; following good frame updates it
        build_frame(8'h01, 1, 8'h0C, 1'b1); send_fr(0); idle(2);
        chk("t3_led_kept", int'(bus.led_o), 'h7);
        chk("t3_code", int'(bus.err_code_o), 2);
        build_frame(8'h01, 1, 8'h03, 1'b0); send_fr(0); idle(2);
        chk("t3_led_new", int'(bus.led_o), 'h3);

        // LEN boundaries
        send(8'hA5, 0); send(8'h05, 0); send(8'h00, 0); idle(2);
        chk("t4_len0_code", int'(bus.err_code_o), 1);
        send(8'hA5, 0); send(8'h05, 0); send(8'(MAXL + 1), 0); idle(2);
        chk("t4_lenmax1_code", int'(bus.err_code_o), 1);
        build_frame(8'h01, MAXL, 8'h09, 1'b0); send_fr(2); idle(2);
        chk("t4_maxlen_led", int'(bus.led_o), 'h9);
        chk("t4_maxlen_len", int'(bus.len_o), MAXL);

        // timeout, then a byte landing exactly on the expiry cycle
        send(8'hA5, 0); send(8'h01, 0); idle(T + 1); idle(1);
        chk("t5_tmo_code", int'(bus.err_code_o), 3);
        chk("t5_tmo_seen", sbq.size(), 0);
        send(8'hA5, 0); send(8'h01, 0); send(8'h01, T); send(8'h0B, 0); send(8'h0B, 0); idle(2);
        chk("t5_edge_led", int'(bus.led_o), 'hB);
        chk("t5_edge_code", int'(bus.err_code_o), 3);

        // junk before a frame
        send(8'h00, 0); send(8'hFF, 1); send(8'h5A, 0);
        build_frame(8'h01, 1, 8'h05, 1'b0); send_fr(0); idle(2);
        chk("t6_junk_led", int'(bus.led_o), 'h5);

        // reset in the middle of a payload
        send(8'hA5, 0); send(8'h01, 0); send(8'h03, 0); send(8'h11, 0); idle(1);
        chk("t6_pre_reset_drained", sbq.size(), 0);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        check_zero("midreset");
        rst_n = 1'b1;
        @(negedge clk);
        build_frame(8'h01, 2, 8'h0E, 1'b0); send_fr(1); idle(2);
        chk("t6_after_reset_led", int'(bus.led_o), 'hE);

        // randomized traffic
        for (int it = 0; it < 150; it++) begin
            r = int'($urandom_range(0, 19));
            c = ($urandom_range(0, 1) == 1) ? 8'h01 : 8'($urandom_range(0, 255));
            if (r < 2) begin
                repeat ($urandom_range(1, 3)) send(8'($urandom_range(0, 255)), int'($urandom_range(0, 3)));
            end else if (r < 4) begin
                send(8'hA5, 0); send(c, 0);
                send(($urandom_range(0, 1) == 1) ? 8'h00 : 8'($urandom_range(MAXL + 1, 255)), 0);
            end else if (r == 4) begin
                build_frame(c, int'($urandom_range(1, MAXL)), 8'($urandom_range(0, 255)), 1'b0);
                fr = fr[0:int'($urandom_range(1, fr.size() - 2))];
                send_fr(2);
                idle(T + 1 + int'($urandom_range(0, 3)));
            end else if (r == 5) begin
                build_frame(c, int'($urandom_range(1, 4)), 8'($urandom_range(0, 255)), 1'b0);
                foreach (fr[i]) send(fr[i], (i == 2) ? T : 0);
            end else begin
                build_frame(c, int'($urandom_range(1, MAXL)), 8'($urandom_range(0, 255)),
                            ($urandom_range(0, 3) == 0));
                send_fr(3);
            end
        end

        idle(T + 2);
        idle(2);
        chk("sb_drain", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
